// File: rtl/operand_trace_buffer.sv
// Triggered circular capture of {pc, op1, op2} per issued instruction, read out after capture ends.
// Optional macro TRACE_TIMESTAMP_EN prepends a free-running timestamp to every stored entry.
module operand_trace_buffer #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 10,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16,
  localparam int AW    = $clog2(DEPTH),
`ifdef TRACE_TIMESTAMP_EN
  localparam int ENTRY_W = TS_W + PC_W + 2*DATA_W
`else
  localparam int ENTRY_W = PC_W + 2*DATA_W
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cap_valid,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [DATA_W-1:0]  op1_in,
  input  logic [DATA_W-1:0]  op2_in,
  input  logic               arm,
  input  logic               stop,
  input  logic [PC_W-1:0]    trig_pc,
  input  logic               wrap_mode,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [ENTRY_W-1:0] rd_data,
  output logic [AW:0]        count,
  output logic [1:0]         state,
  output logic               overflow
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ARMED   = 2'b01,
    S_CAPTURE = 2'b10,
    S_DONE    = 2'b11
  } state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t             state_q, state_d;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count_q;
  logic               overflow_q;
  logic               mode_q;
  logic               clear, wr_en, pop;
  logic [ENTRY_W-1:0] wr_entry;

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_q + 1'b1;
  end

  assign wr_entry = {ts_q, pc_in, op1_in, op2_in};
`else
  assign wr_entry = {pc_in, op1_in, op2_in};
`endif

  // Read handshake: an entry transfers on a rising edge where rd_valid && rd_ready;
  // rd_data shows the oldest entry and holds while rd_valid is high and not accepted.
  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    wr_en   = 1'b0;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d = S_ARMED;
          clear   = 1'b1;
        end
      end
      S_ARMED: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (cap_valid && pc_in == trig_pc) begin
          state_d = S_CAPTURE;
          wr_en   = 1'b1;
        end
      end
      S_CAPTURE: begin
        wr_en = cap_valid && !(!mode_q && count_q == FULL);
        // In stop-when-full mode the write that fills the buffer ends capture on the same edge.
        if (stop || (wr_en && !mode_q && count_q == FULL - 1'b1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (count_q == '0) begin
          state_d = S_IDLE;
        end else if (rd_ready) begin
          pop = 1'b1;
          if (count_q == (AW+1)'(1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_q <= 1'b0;
      mode_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (clear) begin
        count_q    <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        overflow_q <= 1'b0;
        mode_q     <= wrap_mode;
      end else begin
        if (wr_en) begin
          wr_ptr <= wr_ptr + 1'b1;
          // Only reachable in wrap mode: the oldest entry is dropped to make room.
          if (count_q == FULL) begin
            rd_ptr     <= rd_ptr + 1'b1;
            overflow_q <= 1'b1;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        if (pop) begin
          rd_ptr  <= rd_ptr + 1'b1;
          count_q <= count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_entry;
  end

  assign rd_data  = mem[rd_ptr];
  assign rd_valid = (state_q == S_DONE) && (count_q != '0);
  assign count    = count_q;
  assign state    = state_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_operand_trace_buffer.sv
// Self-checking bench for operand_trace_buffer: directed scenarios plus random traffic,
// compared every cycle against a queue-based trace model.
module tb_operand_trace_buffer;

  localparam int DATA_W = 8;
  localparam int PC_W   = 10;
  localparam int DEPTH  = 16;
  localparam int TS_W   = 16;
  localparam int AW     = $clog2(DEPTH);
`ifdef TRACE_TIMESTAMP_EN
  localparam int ENTRY_W = TS_W + PC_W + 2*DATA_W;
`else
  localparam int ENTRY_W = PC_W + 2*DATA_W;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               cap_valid = 1'b0;
  logic [PC_W-1:0]    pc_in = '0;
  logic [DATA_W-1:0]  op1_in = '0;
  logic [DATA_W-1:0]  op2_in = '0;
  logic               arm = 1'b0;
  logic               stop = 1'b0;
  logic [PC_W-1:0]    trig_pc = '0;
  logic               wrap_mode = 1'b0;
  logic               rd_valid;
  logic               rd_ready = 1'b0;
  logic [ENTRY_W-1:0] rd_data;
  logic [AW:0]        count;
  logic [1:0]         state;
  logic               overflow;

  int checks = 0;
  int failures = 0;

  // Model: the trace is a queue holding the oldest entry at the front.
  logic [ENTRY_W-1:0] exp_q[$];
  int   m_state = 0;  // 0 idle, 1 armed, 2 capture, 3 done
  logic m_ovf = 1'b0;
  logic m_mode = 1'b0;
  logic [TS_W-1:0] m_ts = '0;

  operand_trace_buffer #(.DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk(clk), .reset(reset), .cap_valid(cap_valid), .pc_in(pc_in), .op1_in(op1_in),
    .op2_in(op2_in), .arm(arm), .stop(stop), .trig_pc(trig_pc), .wrap_mode(wrap_mode),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .count(count),
    .state(state), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PC_W-1:0] pc_of(input logic [ENTRY_W-1:0] e);
    return e[2*DATA_W +: PC_W];
  endfunction

  function automatic logic [ENTRY_W-1:0] cur_entry();
`ifdef TRACE_TIMESTAMP_EN
    return {m_ts, pc_in, op1_in, op2_in};
`else
    return {pc_in, op1_in, op2_in};
`endif
  endfunction

  task automatic record();
    exp_q.push_back(cur_entry());
    if (exp_q.size() > DEPTH) begin
      void'(exp_q.pop_front());
      m_ovf = 1'b1;
    end
  endtask

  // One clock edge of trace behaviour, from the inputs present at that edge.
  task automatic model_step();
    case (m_state)
      0: if (arm) begin
        m_state = 1; exp_q.delete(); m_ovf = 1'b0; m_mode = wrap_mode;
      end
      1: if (stop) m_state = 0;
         else if (cap_valid && pc_in == trig_pc) begin record(); m_state = 2; end
      2: begin
        if (cap_valid) begin
          record();
          if (!m_mode && exp_q.size() == DEPTH) m_state = 3;
        end
        if (stop) m_state = 3;
      end
      default: begin
        if (exp_q.size() == 0) m_state = 0;
        else if (rd_ready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) m_state = 0;
        end
      end
    endcase
    m_ts = m_ts + 1'b1;
  endtask

  task automatic check_all(input string tag);
    logic exp_rv;
    exp_rv = (m_state == 3) && (exp_q.size() != 0);
    chk({tag, ".state"}, 64'(state), 64'(m_state));
    chk({tag, ".count"}, 64'(count), 64'(exp_q.size()));
    chk({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
    chk({tag, ".rd_valid"}, 64'(rd_valid), 64'(exp_rv));
    if (exp_rv) chk({tag, ".rd_data"}, 64'(rd_data), 64'(exp_q[0]));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic set_in(input logic cv, input logic [PC_W-1:0] pc, input logic a,
                        input logic s, input logic rr);
    cap_valid = cv; pc_in = pc; arm = a; stop = s; rd_ready = rr;
    op1_in = DATA_W'($urandom); op2_in = DATA_W'($urandom);
  endtask

  task automatic arm_with(input logic mode, input logic [PC_W-1:0] trig);
    trig_pc = trig; wrap_mode = mode;
    set_in(1'b0, '0, 1'b1, 1'b0, 1'b0);
    tick("arm");
    arm = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < DEPTH + 2 && rd_valid; i++) begin
      set_in(1'b0, '0, 1'b0, 1'b0, 1'b1);
      tick(tag);
    end
    rd_ready = 1'b0;
    chk({tag, ".drained_idle"}, 64'(state), 64'd0);
  endtask

  // Asynchronous reset between edges: outputs must clear before the next edge.
  task automatic do_reset(input string tag);
    #3;
    reset = 1'b1;
    #1;
    chk({tag, ".state"}, 64'(state), 64'd0);
    chk({tag, ".count"}, 64'(count), 64'd0);
    chk({tag, ".overflow"}, 64'(overflow), 64'd0);
    chk({tag, ".rd_valid"}, 64'(rd_valid), 64'd0);
    exp_q.delete(); m_state = 0; m_ovf = 1'b0; m_mode = 1'b0; m_ts = '0;
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    // Power-on reset
    #1;
    chk("por.state", 64'(state), 64'd0);
    chk("por.count", 64'(count), 64'd0);
    chk("por.rd_valid", 64'(rd_valid), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset in the middle of a capture after 5 writes
    arm_with(1'b0, 10'h020);
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 10'(10'h020 + i), 1'b0, 1'b0, 1'b0);
      tick("t1.cap");
    end
    chk("t1.count_before", 64'(count), 64'd5);
    do_reset("t1.reset");

    // Stop-when-full: trigger at 0x010, fill to 16 entries, read in order
    arm_with(1'b0, 10'h010);
    for (int p = 'h00E; p <= 'h01F; p++) begin
      set_in(1'b1, 10'(p), 1'b0, 1'b0, 1'b0);
      op1_in = 8'(p); op2_in = ~8'(p);
      tick("t2.cap");
      if (p == 'h010) chk("t2.trig_capture", 64'(state), 64'd2);
    end
    chk("t2.done", 64'(state), 64'd3);
    chk("t2.count", 64'(count), 64'd16);
    for (int i = 0; i < DEPTH; i++) begin
      chk("t2.rd_pc", 64'(pc_of(rd_data)), 64'(10'h010 + i));
      set_in(1'b0, '0, 1'b0, 1'b0, 1'b1);
      tick("t2.read");
    end
    chk("t2.idle", 64'(state), 64'd0);

    // Wrap mode: 20 captures from 0x100 keep the newest 16
    arm_with(1'b1, 10'h100);
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, 10'(10'h100 + i), 1'b0, 1'b0, 1'b0);
      tick("t3.cap");
    end
    set_in(1'b0, '0, 1'b0, 1'b1, 1'b0);
    tick("t3.stop");
    chk("t3.count", 64'(count), 64'd16);
    chk("t3.overflow", 64'(overflow), 64'd1);
    chk("t3.first_pc", 64'(pc_of(rd_data)), 64'h104);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) chk("t3.last_pc", 64'(pc_of(rd_data)), 64'h113);
      set_in(1'b0, '0, 1'b0, 1'b0, 1'b1);
      tick("t3.read");
    end

    // Stop together with a capture still records that capture
    arm_with(1'b0, 10'h040);
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 10'(10'h040 + i), 1'b0, 1'b0, 1'b0);
      tick("t4.cap");
    end
    set_in(1'b1, 10'h044, 1'b0, 1'b1, 1'b0);
    tick("t4.stop");
    chk("t4.count", 64'(count), 64'd5);
    drain("t4");

    // Stop and trigger in the same ARMED cycle: stop wins; re-arm works normally
    arm_with(1'b0, 10'h055);
    set_in(1'b1, 10'h055, 1'b0, 1'b1, 1'b0);
    tick("t5.stop_trig");
    chk("t5.idle", 64'(state), 64'd0);
    chk("t5.count", 64'(count), 64'd0);
    arm_with(1'b0, 10'h055);
    set_in(1'b1, 10'h055, 1'b0, 1'b0, 1'b0);
    tick("t5.trig");
    chk("t5.capture", 64'(state), 64'd2);
    set_in(1'b0, '0, 1'b0, 1'b1, 1'b0);
    tick("t5.stop");
    drain("t5");

    // Readout with rd_ready pattern 1,0,1,1,1 from four entries
    arm_with(1'b0, 10'h077);
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 10'(10'h077 + i), 1'b0, 1'b0, 1'b0);
      tick("t6.cap");
    end
    set_in(1'b1, 10'h07A, 1'b0, 1'b1, 1'b0);
    tick("t6.stop");
    chk("t6.count4", 64'(count), 64'd4);
    for (int i = 0; i < 5; i++) begin
      logic [4:0] pat;
      int exp_cnt[5];
      pat = 5'b11101;
      exp_cnt = '{3, 3, 2, 1, 0};
      set_in(1'b0, '0, 1'b0, 1'b0, pat[i]);
      tick("t6.read");
      chk("t6.count_step", 64'(count), 64'(exp_cnt[i]));
    end
    chk("t6.rd_valid_low", 64'(rd_valid), 64'd0);
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick("t6.after");
    chk("t6.idle", 64'(state), 64'd0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      set_in(1'($urandom_range(0, 1)), 10'($urandom_range(0, 7)),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 24) == 0),
             1'($urandom_range(0, 1)));
      trig_pc = 10'($urandom_range(0, 7));
      wrap_mode = 1'($urandom_range(0, 1));
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
